// File: rtl/spike_threshold_unit.sv
// Spike threshold stage: float32 threshold compare, post-spike potential select and per-neuron refractory tracking.
// Optional SPIKE_COUNT_EN adds a saturating per-neuron spike counter with a combinational read port.
module spike_threshold_unit #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned REFRAC_W    = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [31:0]         cfg_threshold,
  input  logic [31:0]         cfg_reset_pot,
  input  logic [REFRAC_W-1:0] cfg_refractory,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [31:0]         in_potential,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [31:0]         out_potential,
  output logic                out_spike
`ifdef SPIKE_COUNT_EN
  ,
  input  logic [ADDR_W-1:0]   cnt_addr,
  output logic [15:0]         cnt_value
`endif
);

  localparam logic [31:0]  THRESHOLD_RST = 32'h4120_0000;
  localparam int unsigned  CNT_W         = 16;

  logic [31:0]         threshold_q  [NUM_NEURONS];
  logic [31:0]         reset_pot_q  [NUM_NEURONS];
  logic [REFRAC_W-1:0] refractory_q [NUM_NEURONS];
  logic [REFRAC_W-1:0] refrac_q     [NUM_NEURONS];

  logic        accept;
  logic        in_refrac;
  logic        fire;
  logic        res_spike;
  logic [31:0] res_pot;

  // Float32 a >= b: sign-magnitude ordering, signed zeros equal, any NaN yields 0.
  function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
    logic a_nan;
    logic b_nan;
    logic ge;
    a_nan = (&a[30:23]) & (|a[22:0]);
    b_nan = (&b[30:23]) & (|b[22:0]);
    if (a_nan || b_nan)                      ge = 1'b0;
    else if (a[30:0] == '0 && b[30:0] == '0) ge = 1'b1;
    else if (a[31] != b[31])                 ge = b[31];
    else if (!a[31])                         ge = (a[30:0] >= b[30:0]);
    else                                     ge = (a[30:0] <= b[30:0]);
    return ge;
  endfunction

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Decision for the neuron currently presented on the input.
  always_comb begin
    in_refrac = (refrac_q[in_addr] != '0);
    fire      = fp_ge(in_potential, threshold_q[in_addr]);
    res_spike = 1'b0;
    res_pot   = in_potential;
    if (in_refrac) begin
      res_pot = reset_pot_q[in_addr];
    end else if (fire) begin
      res_spike = 1'b1;
      res_pot   = reset_pot_q[in_addr];
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        threshold_q[i]  <= THRESHOLD_RST;
        reset_pot_q[i]  <= '0;
        refractory_q[i] <= '0;
      end
    end else if (cfg_we) begin
      threshold_q[cfg_addr]  <= cfg_threshold;
      reset_pot_q[cfg_addr]  <= cfg_reset_pot;
      refractory_q[cfg_addr] <= cfg_refractory;
    end
  end

  // A config write to a neuron overrides any refractory update from a same-cycle accept.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        refrac_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        if (cfg_we && cfg_addr == ADDR_W'(i)) begin
          refrac_q[i] <= '0;
        end else if (accept && in_addr == ADDR_W'(i)) begin
          if (in_refrac) begin
            refrac_q[i] <= refrac_q[i] - REFRAC_W'(1);
          end else if (fire) begin
            refrac_q[i] <= refractory_q[i];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      out_valid     <= 1'b0;
      out_addr      <= '0;
      out_potential <= '0;
      out_spike     <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_addr      <= in_addr;
      out_potential <= res_pot;
      out_spike     <= res_spike;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_NEURONS];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        if (cfg_we && cfg_addr == ADDR_W'(i)) begin
          cnt_q[i] <= '0;
        end else if (accept && res_spike && in_addr == ADDR_W'(i) && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_value = cnt_q[cnt_addr];
`endif

endmodule

// File: tb/tb_spike_threshold_unit.sv
// Self-checking bench for spike_threshold_unit: directed steps, scoreboard of expected results.
module tb_spike_threshold_unit;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_threshold;
  logic [31:0] cfg_reset_pot;
  logic [3:0]  cfg_refractory;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_addr;
  logic [31:0] in_potential;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_addr;
  logic [31:0] out_potential;
  logic        out_spike;
`ifdef SPIKE_COUNT_EN
  logic [1:0]  cnt_addr = 2'd0;
  logic [15:0] cnt_value;
`endif

  spike_threshold_unit dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_threshold(cfg_threshold),
    .cfg_reset_pot(cfg_reset_pot), .cfg_refractory(cfg_refractory),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_potential(in_potential),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_potential(out_potential), .out_spike(out_spike)
`ifdef SPIKE_COUNT_EN
    , .cnt_addr(cnt_addr), .cnt_value(cnt_value)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] pot;
    logic        spike;
  } result_t;

  result_t     sb[$];
  int          vectors = 0;
  int          fails   = 0;
  logic        exp_ov;
  logic [31:0] m_thr [4];
  logic [31:0] m_rp  [4];
  int          m_rf  [4];
  int          m_rc  [4];
  int          m_cnt [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Float32 bits to real value; NaN is screened separately, infinity maps to a huge value.
  function automatic real f2r(input logic [31:0] b);
    real mag;
    int  e;
    e = int'(b[30:23]);
    if (e == 0)        mag = real'(b[22:0]) * (2.0 ** -149);
    else if (e == 255) mag = 1.0e300;
    else               mag = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -mag : mag;
  endfunction

  function automatic logic model_ge(input logic [31:0] a, input logic [31:0] b);
    logic nan;
    nan = (a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0);
    return !nan && (f2r(a) >= f2r(b));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_thr[i] = 32'h4120_0000; m_rp[i] = '0; m_rf[i] = 0; m_rc[i] = 0; m_cnt[i] = 0;
    end
    sb.delete();
    exp_ov = 1'b0;
  endtask

  // Reference model and output checker, evaluated mid-cycle on what the next rising edge will see.
  always @(negedge CLK) begin
    result_t e;
    logic    acc;
    int      a;
    if (!RESET_N) begin
      model_reset();
    end else begin
      chk("in_ready", in_ready, !exp_ov || out_ready);
      chk("out_valid", out_valid, exp_ov);
`ifdef SPIKE_COUNT_EN
      chk("cnt_value", cnt_value, m_cnt[cnt_addr]);
      cnt_addr = cnt_addr + 2'd1;
`endif
      if (exp_ov) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb[0];
          chk("out_addr", out_addr, e.addr);
          chk("out_potential", out_potential, e.pot);
          chk("out_spike", out_spike, e.spike);
          if (out_ready) void'(sb.pop_front());
        end
      end
      acc = in_valid && (!exp_ov || out_ready);
      if (acc) begin
        a = int'(in_addr);
        e.addr = in_addr;
        if (m_rc[a] != 0) begin
          e.spike = 1'b0; e.pot = m_rp[a]; m_rc[a]--;
        end else if (model_ge(in_potential, m_thr[a])) begin
          e.spike = 1'b1; e.pot = m_rp[a]; m_rc[a] = m_rf[a];
          if (m_cnt[a] < 65535) m_cnt[a]++;
        end else begin
          e.spike = 1'b0; e.pot = in_potential;
        end
        sb.push_back(e);
      end
      if (cfg_we) begin
        a = int'(cfg_addr);
        m_thr[a] = cfg_threshold; m_rp[a] = cfg_reset_pot; m_rf[a] = int'(cfg_refractory);
        m_rc[a] = 0; m_cnt[a] = 0;
      end
      exp_ov = acc ? 1'b1 : (out_ready ? 1'b0 : exp_ov);
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [31:0] thr, input logic [31:0] rp,
                     input logic [3:0] rf);
    cfg_we = 1'b1; cfg_addr = a; cfg_threshold = thr; cfg_reset_pot = rp; cfg_refractory = rf;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic send_chk(input logic [1:0] a, input logic [31:0] p, input logic exp_s,
                          input string tag);
    in_valid = 1'b1; in_addr = a; in_potential = p;
    cycle();
    in_valid = 1'b0;
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk(tag, out_spike, exp_s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    RESET_N = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_threshold = '0; cfg_reset_pot = '0;
    cfg_refractory = '0; in_valid = 1'b0; in_addr = '0; in_potential = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_potential", out_potential, 32'h0);
    chk("rst_out_spike", out_spike, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    cycle(); cycle();
    RESET_N = 1'b1;
    cycle();

    // T1 / T2
    send_chk(2'd0, 32'h41DE_D852, 1'b1, "t1_spike");
    chk("t1_pot", out_potential, 32'h0);
    send_chk(2'd1, 32'h40A0_0000, 1'b0, "t2_spike");
    chk("t2_pot", out_potential, 32'h40A0_0000);

    // T3: refractory 2 on neuron 2, refractory 0 on neuron 3
    cfg(2'd2, 32'h4120_0000, 32'h0, 4'd2);
    send_chk(2'd2, 32'h42C8_0000, 1'b1, "t3_a");
    send_chk(2'd2, 32'h42C8_0000, 1'b0, "t3_b");
    send_chk(2'd2, 32'h42C8_0000, 1'b0, "t3_c");
    chk("t3_c_pot", out_potential, 32'h0);
    send_chk(2'd2, 32'h42C8_0000, 1'b1, "t3_d");
    for (int i = 0; i < 4; i++) send_chk(2'd3, 32'h42C8_0000, 1'b1, "t3_r0");

    // T4: backpressure then full-rate drain
    out_ready = 1'b0; in_valid = 1'b1; in_addr = 2'd1; in_potential = 32'h3F80_0000;
    for (int i = 0; i < 5; i++) cycle();
    chk("t4_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_addr = 2'($urandom_range(1, 3));
      in_potential = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
      cycle();
    end
    in_valid = 1'b0;
    cycle(); cycle();
    chk("t4_drained", 32'(sb.size()), 32'd0);

    // T5: float edge cases on neuron 0
    cfg(2'd0, 32'hBF80_0000, 32'h3F00_0000, 4'd0);
    send_chk(2'd0, 32'hBF00_0000, 1'b1, "t5_neg_half");
    send_chk(2'd0, 32'hC000_0000, 1'b0, "t5_neg_two");
    chk("t5_pass_pot", out_potential, 32'hC000_0000);
    send_chk(2'd0, 32'h7FC0_0000, 1'b0, "t5_nan");
    cfg(2'd0, 32'h0000_0000, 32'h3F00_0000, 4'd0);
    send_chk(2'd0, 32'h8000_0000, 1'b1, "t5_neg_zero");
    cfg(2'd0, 32'h0000_0002, 32'h0, 4'd0);
    send_chk(2'd0, 32'h0000_0001, 1'b0, "t5_denorm_lt");
    send_chk(2'd0, 32'h0000_0003, 1'b1, "t5_denorm_gt");

    // T6: async reset mid-stream clears refractory state
    cfg(2'd2, 32'h4120_0000, 32'h0, 4'd3);
    send_chk(2'd2, 32'h42C8_0000, 1'b1, "t6_pre");
    in_valid = 1'b1; in_addr = 2'd2; in_potential = 32'h42C8_0000;
    cycle();
    RESET_N = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    cycle();
    RESET_N = 1'b1;
    cycle();
    send_chk(2'd2, 32'h42C8_0000, 1'b1, "t6_post_a");
    send_chk(2'd2, 32'h42C8_0000, 1'b1, "t6_post_b");

    // T6: same-cycle config and accept use the old threshold
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_threshold = 32'h4348_0000;
    cfg_reset_pot = 32'h0; cfg_refractory = 4'd0;
    send_chk(2'd1, 32'h42C8_0000, 1'b1, "t6_race_old");
    cfg_we = 1'b0;
    send_chk(2'd1, 32'h42C8_0000, 1'b0, "t6_race_new");
    cycle(); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
